// File: rtl/bxs_pkg.sv
// Shared types and constants for the block transfer sequencer.
// Optional base-register writeback is enabled by defining BXS_WRITEBACK_EN.
package bxs_pkg;

  localparam int   WORD_BYTES   = 4;
  localparam logic RF_LE_ACTIVE = 1'b0;
  localparam int   REG_IDX_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ACCESS,
    WRITE,
`ifdef BXS_WRITEBACK_EN
    WB,
`endif
    DONE
  } bxs_state_t;

  function automatic logic [31:0] step_addr(input logic [31:0] addr, input logic up);
    return up ? addr + 32'(WORD_BYTES) : addr - 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/bxs_lsb_find.sv
// Combinational lowest-set-bit finder over a 16-bit register mask.
module bxs_lsb_find
  import bxs_pkg::*;
(
  input  logic [15:0]          i_vec,
  output logic [REG_IDX_W-1:0] o_idx,
  output logic                 o_vld
);

  // Scanning from the top down lets the lowest set bit overwrite any higher one.
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = REG_IDX_W'(i);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_xfer_seq.sv
// LDM/STM-style block transfer sequencer between a register file and memory.
// Define BXS_WRITEBACK_EN to add the base-register writeback (WB) state.
module block_xfer_seq
  import bxs_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        is_load,
  input  logic        up,
  input  logic [15:0] reg_list,
  input  logic [31:0] base_addr,
  input  logic [3:0]  rn,
  input  logic [31:0] rf_y0,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  rf_ra,
  output logic [3:0]  rf_rc,
  output logic [31:0] rf_i,
  output logic        rf_le,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic [4:0]  count,
  output logic [2:0]  o_dbg_state
);

  bxs_state_t r_state;
  bxs_state_t w_next;
  bxs_state_t w_after_xfer;

  logic [15:0] r_pending;
  logic        r_is_load;
  logic        r_up;
  logic [31:0] r_addr;
  logic [4:0]  r_count;
  logic [3:0]  r_idx;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic [3:0]  w_lsb_idx;
  logic        w_lsb_vld;
  logic [15:0] w_pending_clr;

`ifdef BXS_WRITEBACK_EN
  logic [3:0]  r_rn;
  logic [31:0] w_final_addr;
  // r_addr has moved one step past the last transfer; a descending run
  // started one word below base, so add that word back.
  assign w_final_addr = r_up ? r_addr : r_addr + 32'(WORD_BYTES);
`else
  logic w_unused_rn;
  assign w_unused_rn = ^rn;
`endif

  bxs_lsb_find u_lsb_find (
    .i_vec (r_pending),
    .o_idx (w_lsb_idx),
    .o_vld (w_lsb_vld)
  );

  // In WRITE the current bit is already clear, so this mask is valid in both
  // ACCESS and WRITE when deciding where the transfer goes next.
  assign w_pending_clr = r_pending & ~(16'h0001 << r_idx);

  always_comb begin
    w_after_xfer = DONE;
    if (w_pending_clr != 16'h0000) begin
      w_after_xfer = SCAN;
    end else begin
`ifdef BXS_WRITEBACK_EN
      w_after_xfer = WB;
`else
      w_after_xfer = DONE;
`endif
    end
  end

  // Memory handshake: mem_req is held with stable mem_addr/mem_wdata/mem_we
  // until mem_ready is sampled high at a rising edge; the transfer completes
  // on that edge and mem_rdata is captured at the same edge for loads.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (start) w_next = (reg_list != 16'h0000) ? SCAN : DONE;
      SCAN:   w_next = w_lsb_vld ? ACCESS : DONE;
      ACCESS: if (mem_ready) w_next = r_is_load ? WRITE : w_after_xfer;
      WRITE:  w_next = w_after_xfer;
`ifdef BXS_WRITEBACK_EN
      WB:     w_next = DONE;
`endif
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_is_load <= 1'b0;
      r_up      <= 1'b0;
      r_addr    <= '0;
      r_count   <= '0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
`ifdef BXS_WRITEBACK_EN
      r_rn      <= '0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_pending <= reg_list;
            r_is_load <= is_load;
            r_up      <= up;
            r_addr    <= up ? base_addr : base_addr - 32'(WORD_BYTES);
            r_count   <= '0;
`ifdef BXS_WRITEBACK_EN
            r_rn      <= rn;
`endif
          end
        end
        SCAN: begin
          r_idx   <= w_lsb_idx;
          r_wdata <= rf_y0;
        end
        ACCESS: begin
          if (mem_ready) begin
            r_pending <= w_pending_clr;
            r_addr    <= step_addr(r_addr, r_up);
            r_count   <= r_count + 5'd1;
            r_rdata   <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rf_ra = (r_state == SCAN) ? w_lsb_idx : r_idx;
    rf_rc = '0;
    rf_i  = '0;
    rf_le = ~RF_LE_ACTIVE;
    case (r_state)
      WRITE: begin
        rf_le = RF_LE_ACTIVE;
        rf_rc = r_idx;
        rf_i  = r_rdata;
      end
`ifdef BXS_WRITEBACK_EN
      WB: begin
        rf_le = RF_LE_ACTIVE;
        rf_rc = r_rn;
        rf_i  = w_final_addr;
      end
`endif
      default: ;
    endcase
  end

  assign mem_req     = (r_state == ACCESS);
  assign mem_we      = (r_state == ACCESS) && !r_is_load;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign count       = r_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_block_xfer_seq.sv
// Self-checking bench for block_xfer_seq: register-file and memory models,
// expected-transaction queues, directed and random transfer operations.
module tb_block_xfer_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        is_load;
  logic        up;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic [3:0]  rn;
  logic [31:0] rf_y0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [3:0]  rf_ra;
  logic [3:0]  rf_rc;
  logic [31:0] rf_i;
  logic        rf_le;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [4:0]  count;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rf_mem [16];
  logic [64:0] exp_mem_q[$];
  logic [35:0] exp_rf_q[$];
  logic [31:0] ld_data_q[$];
  logic [31:0] fixed_q[$];

  int cfg_wait = 0;
  int wait_cnt = 0;
  int rf_pulses = 0;
  int mem_accepts = 0;
  int done_pulses = 0;

  block_xfer_seq dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .is_load     (is_load),
    .up          (up),
    .reg_list    (reg_list),
    .base_addr   (base_addr),
    .rn          (rn),
    .rf_y0       (rf_y0),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .rf_ra       (rf_ra),
    .rf_rc       (rf_rc),
    .rf_i        (rf_i),
    .rf_le       (rf_le),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- register file model ----------------
  assign rf_y0 = rf_mem[rf_ra];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 32'h1000_0000 + 32'(i) * 32'h0101_0111;
    end else if (rf_le === 1'b0) begin
      rf_mem[rf_rc] <= rf_i;
    end
  end

  // ---------------- memory responder ----------------
  always @(posedge clk) begin
    #1;
    mem_rdata = (ld_data_q.size() > 0) ? ld_data_q[0] : 32'h0;
    if (mem_req !== 1'b1) begin
      wait_cnt  = 0;
      mem_ready = 1'b0;
    end else if (wait_cnt >= cfg_wait) begin
      mem_ready = 1'b1;
    end else begin
      mem_ready = 1'b0;
      wait_cnt++;
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] prev_wdata = 32'h0;

  always @(negedge clk) begin
    logic [64:0] em;
    logic [35:0] er;
    if (mem_req === 1'b1 && mem_ready) begin
      mem_accepts++;
      check_eq("mem_q_avail", 64'(exp_mem_q.size() > 0), 64'd1);
      if (exp_mem_q.size() > 0) begin
        em = exp_mem_q.pop_front();
        check_eq("mem_we", 64'(mem_we), 64'(em[64]));
        check_eq("mem_addr", 64'(mem_addr), 64'(em[63:32]));
        if (em[64]) check_eq("mem_wdata", 64'(mem_wdata), 64'(em[31:0]));
        if (!em[64] && ld_data_q.size() > 0) void'(ld_data_q.pop_front());
      end
    end
    if (mem_req === 1'b1 && !mem_ready) begin
      if (prev_wait) begin
        check_eq("wait_addr_stable", 64'(mem_addr), 64'(prev_addr));
        check_eq("wait_wdata_stable", 64'(mem_wdata), 64'(prev_wdata));
      end
      prev_wait  = 1'b1;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
    end else begin
      prev_wait = 1'b0;
    end
    if (rf_le === 1'b0) begin
      rf_pulses++;
      check_eq("rf_q_avail", 64'(exp_rf_q.size() > 0), 64'd1);
      if (exp_rf_q.size() > 0) begin
        er = exp_rf_q.pop_front();
        check_eq("rf_rc", 64'(rf_rc), 64'(er[35:32]));
        check_eq("rf_i", 64'(rf_i), 64'(er[31:0]));
      end
    end
    if (done === 1'b1) done_pulses++;
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic ld, input logic up_i, input logic [15:0] list,
                        input logic [31:0] base, input logic [3:0] rn_i, input int wait_i);
    logic [31:0] a;
    logic [31:0] d;
    int n = 0;
    int exp_pulses;
    int cycles;
    int s_rf, s_mem, s_done;
    a = up_i ? base : base - 32'd4;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        if (ld) begin
          d = (fixed_q.size() > 0) ? fixed_q.pop_front() : $urandom;
          ld_data_q.push_back(d);
          exp_rf_q.push_back({4'(i), d});
          exp_mem_q.push_back({1'b0, a, 32'h0});
        end else begin
          exp_mem_q.push_back({1'b1, a, rf_mem[i]});
        end
        a = up_i ? a + 32'd4 : a - 32'd4;
        n++;
      end
    end
    exp_pulses = ld ? n : 0;
`ifdef BXS_WRITEBACK_EN
    if (n > 0) begin
      exp_rf_q.push_back({rn_i, up_i ? base + 32'(4 * n) : base - 32'(4 * n)});
      exp_pulses++;
    end
`endif
    s_rf = rf_pulses; s_mem = mem_accepts; s_done = done_pulses;
    cfg_wait = wait_i;
    @(negedge clk);
    is_load = ld; up = up_i; reg_list = list; base_addr = base; rn = rn_i; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    is_load = $urandom_range(0, 1); up = $urandom_range(0, 1);
    reg_list = 16'($urandom); base_addr = $urandom; rn = 4'($urandom);
    cycles = 1;
    while (!done && cycles < 400) begin
      if (cycles == 1 && n > 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cycles++;
    end
    check_eq("done_seen", 64'(done), 64'd1);
    if (n == 0) check_eq("zero_done_latency", 64'(cycles), 64'd1);
    check_eq("count_at_done", 64'(count), 64'(n));
    check_eq("busy_at_done", 64'(busy), 64'd1);
    @(negedge clk);
    check_eq("busy_after", 64'(busy), 64'd0);
    check_eq("done_one_cycle", 64'(done), 64'd0);
    check_eq("rf_pulse_count", 64'(rf_pulses - s_rf), 64'(exp_pulses));
    check_eq("mem_xfer_count", 64'(mem_accepts - s_mem), 64'(n));
    check_eq("done_pulse_count", 64'(done_pulses - s_done), 64'd1);
    check_eq("mem_q_drained", 64'(exp_mem_q.size()), 64'd0);
    check_eq("rf_q_drained", 64'(exp_rf_q.size()), 64'd0);
    exp_mem_q.delete(); exp_rf_q.delete(); ld_data_q.delete();
  endtask

  task automatic clr_mid_access();
    int cycles = 0;
    int s_rf, s_done;
    cfg_wait = 30;
    @(negedge clk);
    is_load = 1'b1; up = 1'b1; reg_list = 16'h00F0; base_addr = 32'h400; rn = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (mem_req !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check_eq("clr_reached_access", 64'(mem_req), 64'd1);
    s_rf = rf_pulses; s_done = done_pulses;
    clr = 1'b1;
    @(negedge clk);
    check_eq("clr_busy", 64'(busy), 64'd0);
    check_eq("clr_mem_req", 64'(mem_req), 64'd0);
    check_eq("clr_rf_le", 64'(rf_le), 64'd1);
    check_eq("clr_done", 64'(done), 64'd0);
    check_eq("clr_count", 64'(count), 64'd0);
    clr = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("clr_no_rf_pulse", 64'(rf_pulses - s_rf), 64'd0);
    check_eq("clr_no_done", 64'(done_pulses - s_done), 64'd0);
    check_eq("clr_idle_busy", 64'(busy), 64'd0);
  endtask

  // ---------------- reset and sequence ----------------
  initial begin
    clr = 1'b1; start = 1'b0; is_load = 1'b0; up = 1'b1;
    reg_list = '0; base_addr = '0; rn = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_rf_le", 64'(rf_le), 64'd1);
    check_eq("rst_mem_req", 64'(mem_req), 64'd0);
    check_eq("rst_mem_we", 64'(mem_we), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_outs", {rf_ra, rf_rc, rf_i}, 64'd0);
    check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'd0);
    clr = 1'b0;
    @(negedge clk);

    run_op(1'b0, 1'b1, 16'h0005, 32'h100, 4'd13, 0);
    fixed_q.push_back(32'hA);
    fixed_q.push_back(32'h8);
    run_op(1'b1, 1'b1, 16'h8001, 32'h200, 4'd3, 0);
    run_op(1'b1, 1'b1, 16'h0010, 32'h300, 4'd2, 5);
    run_op(1'b0, 1'b1, 16'h0000, 32'h500, 4'd4, 0);
    run_op(1'b1, 1'b0, 16'h0000, 32'h600, 4'd4, 0);
    run_op(1'b0, 1'b0, 16'h0E00, 32'h0, 4'd5, 0);
    run_op(1'b1, 1'b1, 16'hFFFF, 32'hFFFF_FFF0, 4'd7, 1);
    for (int k = 0; k < 6; k++) begin
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)),
             $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end
    clr_mid_access();
    run_op(1'b0, 1'b0, 16'h0103, 32'h800, 4'd9, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/block_xfer_seq.md
BLOCK_XFER_SEQ -- requirements
Module: block_xfer_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports clk and clr (listed first below).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 clr  in  1  synchronous active-high reset.
REQ-004 start  in  1  one-cycle request; sampled only in IDLE.
REQ-005 is_load  in  1  1 = memory-to-register (LDM); 0 = register-to-memory (STM).
REQ-006 up  in  1  1 = address +4 per transfer; 0 = address -4 per transfer.
REQ-007 reg_list  in  16  register mask; bit n selects R(n).
REQ-008 base_addr  in  32  starting address.
REQ-009 rn  in  4  base register index, used only for writeback.
REQ-010 rf_y0  in  32  register-file read data; combinational from rf_ra.
REQ-011 mem_ready  in  1  memory accepts/completes the current request.
REQ-012 mem_rdata  in  32  load data, valid when mem_ready=1.
REQ-013 rf_ra, rf_rc  out  4  register-file read index and write index.
REQ-014 rf_i  out  32  register-file write data.
REQ-015 rf_le  out  1  register-file load enable, active low.
REQ-016 mem_req, mem_we  out  1  memory request and write strobe.
REQ-017 mem_addr, mem_wdata  out  32  memory address and store data.
REQ-018 busy, done  out  1  busy = not IDLE; done = one-cycle completion pulse.
REQ-019 count  out  5  transfers completed in the current operation (0..16).

Function
REQ-020 FSM states SHALL be IDLE, SCAN, ACCESS, WRITE, WB, DONE.
REQ-021 IDLE with start=1 SHALL latch reg_list into pending, is_load, up, and rn; set addr to base_addr (up=1) or base_addr-4 (up=0); clear count.
REQ-022 IDLE->SCAN if reg_list is nonzero; IDLE->DONE if reg_list is 0, with no memory access and no writeback.
REQ-023 SCAN SHALL drive rf_ra = index of the lowest set bit of pending for one cycle, capture rf_y0 into mem_wdata, then go to ACCESS.
REQ-024 ACCESS SHALL hold mem_req=1, mem_we=~is_load, and stable mem_addr/mem_wdata until mem_ready=1; the wait is unbounded.
REQ-025 On mem_ready in ACCESS: clear the current pending bit, step addr by ±4 (modulo 2^32), increment count; for a load go to WRITE, otherwise go to the next state per REQ-027.
REQ-026 WRITE SHALL drive rf_le=0 for exactly one cycle, with rf_rc = current index and rf_i = mem_rdata captured at mem_ready.
REQ-027 Next state after a transfer: SCAN if pending≠0; otherwise WB (when writeback is compiled in) or DONE.
REQ-028 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-029 rf_le SHALL be 1 in every state except WRITE and WB; mem_req SHALL be 0 outside ACCESS.
REQ-030 start while busy=1 SHALL be ignored; changes to inputs other than rf_y0, mem_ready, and mem_rdata after the start cycle SHALL be ignored.
REQ-031 Registers SHALL be visited in ascending index order regardless of up.

Reset
REQ-032 clr=1 at a clock edge SHALL force IDLE from any state, including mid-ACCESS, with no further rf_le or mem_req pulse.
REQ-033 Reset values: rf_le=1, mem_req=0, mem_we=0, busy=0, done=0, count=0, and all index/address/data outputs 0.

Configuration
REQ-034 The macro BXS_WRITEBACK_EN SHALL control base-register writeback.
REQ-035 With BXS_WRITEBACK_EN defined, WB SHALL drive rf_le=0, rf_rc=rn, and rf_i = final address for one cycle, then go to DONE. Final address = base_addr + 4·N when up=1, and base_addr − 4·N when up=0.
REQ-036 Without BXS_WRITEBACK_EN, the WB state SHALL be absent, and DONE SHALL follow the last transfer.

Structure
REQ-037 Package bxs_pkg SHALL hold the state enumeration, WORD_BYTES=4, RF_LE_ACTIVE=0, and the register-index width of 4.
REQ-038 Sub-module bxs_lsb_find SHALL be the only sub-module: a combinational 16-bit lowest-set-bit finder producing a 4-bit index and a valid flag.

Verification
REQ-039 STM with reg_list=16'h0005, base=32'h100, up=1, mem_ready tied 1: writes go to 0x100 (data R0) and then 0x104 (data R2); done follows; count=2; rf_le stays 1.
REQ-040 LDM with reg_list=16'h8001, base=32'h200, up=1, mem_rdata 0xA then 0x8: R0←0xA and R15←0x8, each with a one-cycle rf_le=0.
REQ-041 LDM with mem_ready held low for 5 cycles: mem_req and mem_addr stay stable throughout, and exactly one rf_le pulse occurs after ready.
REQ-042 reg_list=0: done occurs 1 cycle after IDLE exits, with no mem_req and no rf_le pulse.
REQ-043 With BXS_WRITEBACK_EN, STM of 3 registers with base=32'h0, up=0: addresses are 0xFFFFFFFC, 0xFFFFFFF8, 0xFFFFFFF4, and the WB write places 0xFFFFFFF4 into rn.
REQ-044 clr=1 asserted during ACCESS of a 4-register LDM: the next cycle shows busy=0, with no rf_le pulse and no done.
